// File: rtl/serial_add_arbiter_pkg.sv
// serial_add_pkg: shared state type, default sizes and round-robin pick for the serial adder arbiter
package serial_add_pkg;
    localparam int NREQ_DEF = 4;
    localparam int WIDTH_DEF = 8;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    typedef struct packed {
        logic found;
        int   idx;
    } pick_t;
    // First set request at or after ptr, wrapping at n; n is at most 32
    function automatic pick_t rr_pick(input logic [31:0] req, input int ptr, input int n);
        pick_t p = '{found: 1'b0, idx: 0};
        for (int k = 0; k < 32; k++) begin
            if (k < n && !p.found && |(req & (32'd1 << ((ptr + k) % n))))
                p = '{found: 1'b1, idx: (ptr + k) % n};
        end
        return p;
    endfunction
endpackage

// File: rtl/serial_add_arbiter_if.sv
// serial_add_arbiter_if: requester-side operand/grant bus and result bus of the shared serial adder
interface serial_add_arbiter_if import serial_add_pkg::*; #(
    parameter int NREQ = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
);
    logic [NREQ-1:0]         req, gnt;
    logic [NREQ*WIDTH-1:0]   op_a, op_b;
    logic                    busy, done, cout, par_even, par_odd;
    logic [$clog2(NREQ)-1:0] done_id;
    logic [WIDTH-1:0]        sum;
    modport master (output req, op_a, op_b, input gnt, busy, done, done_id, sum, cout, par_even, par_odd);
    modport slave (input req, op_a, op_b, output gnt, busy, done, done_id, sum, cout, par_even, par_odd);
endinterface

// File: rtl/serial_add_arbiter_ha_cell.sv
// ha_cell: combinational half adder, two of these plus a carry flop form the shared adder bit
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: round-robin sequencer sharing one bit-serial adder among NREQ requesters
module serial_add_arbiter import serial_add_pkg::*; #(
    parameter int NREQ = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input logic clock,
    input logic reset,
    serial_add_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(WIDTH);
    state_t state, state_n;
    pick_t pick;
    logic [IW-1:0] pidx, ptr, gid;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_n;
    logic [CW-1:0] cnt;
    logic carry, carry_n, ha0, ha1, c0, c1, last;

    ha_cell u_ha0 (.a(a_sh[0]), .b(b_sh[0]), .s(ha0), .c(c0));
    ha_cell u_ha1 (.a(ha0), .b(carry), .s(ha1), .c(c1));

    assign pick = rr_pick(32'(bus.req), int'(ptr), NREQ);
    assign pidx = IW'(pick.idx);
    assign carry_n = c0 | c1;
    assign res_n = WIDTH'({ha1, res_sh} >> 1);
    assign last = cnt == CW'(WIDTH - 1);

    always_ff @(posedge clock)
        state <= !reset ? IDLE : state_n;

    always_comb
        state_n = state == IDLE ? (pick.found ? ADD : IDLE) :
                  state == ADD  ? (last ? DONE : ADD) : IDLE;

    always_comb begin
        bus.gnt = (state == IDLE && pick.found) ? NREQ'(1) << pidx : '0;
        bus.busy = state != IDLE;
        bus.done = state == DONE;
    end

    // Result registers load on the last add cycle so they are valid alongside done
    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr <= '0;
            gid <= '0;
            a_sh <= '0;
            b_sh <= '0;
            res_sh <= '0;
            cnt <= '0;
            carry <= 1'b0;
            bus.done_id <= '0;
            bus.sum <= '0;
            bus.cout <= 1'b0;
            bus.par_even <= 1'b0;
            bus.par_odd <= 1'b1;
        end else if (state == IDLE && pick.found) begin
            a_sh <= bus.op_a[pidx*WIDTH +: WIDTH];
            b_sh <= bus.op_b[pidx*WIDTH +: WIDTH];
            gid <= pidx;
            ptr <= pidx == IW'(NREQ - 1) ? '0 : pidx + 1'b1;
            carry <= 1'b0;
            cnt <= '0;
        end else if (state == ADD) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res_sh <= res_n;
            carry <= carry_n;
            cnt <= cnt + 1'b1;
            if (last) begin
                bus.sum <= res_n;
                bus.cout <= carry_n;
                bus.done_id <= gid;
                bus.par_even <= ^res_n;
                bus.par_odd <= ~^res_n;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb_serial_add_arbiter: directed checks of arbitration order, serial sum, parity, latency and reset abort
module tb_serial_add_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    serial_add_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();
    serial_add_arbiter #(.NREQ(4), .WIDTH(8)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            #1;
            if (bus.done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.req = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        n_chk++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got %b exp 0000", bus.gnt); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
        n_chk++; if (bus.sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum got %h exp 00", bus.sum); end
        n_chk++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b exp 0", bus.cout); end
        n_chk++; if (bus.par_even !== 1'b0) begin n_fail++; $display("FAIL reset_par_even got %b exp 0", bus.par_even); end
        n_chk++; if (bus.par_odd !== 1'b1) begin n_fail++; $display("FAIL reset_par_odd got %b exp 1", bus.par_odd); end
        n_chk++; if (bus.done_id !== 2'd0) begin n_fail++; $display("FAIL reset_done_id got %0d exp 0", bus.done_id); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        @(negedge clock);
        bus.req = 4'b0001;
        bus.op_a[7:0] = 8'h0F;
        bus.op_b[7:0] = 8'h01;
        #1;
        n_chk++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL basic_gnt got %b exp 0001", bus.gnt); end
        @(posedge clock);
        #1 bus.req = '0;
        wait_done(n);
        n_chk++; if (n !== 9) begin n_fail++; $display("FAIL basic_latency got %0d exp 9", n); end
        n_chk++; if (bus.sum !== 8'h10) begin n_fail++; $display("FAIL basic_sum got %h exp 10", bus.sum); end
        n_chk++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL basic_cout got %b exp 0", bus.cout); end
        n_chk++; if (bus.par_even !== 1'b1) begin n_fail++; $display("FAIL basic_par_even got %b exp 1", bus.par_even); end
        n_chk++; if (bus.par_odd !== 1'b0) begin n_fail++; $display("FAIL basic_par_odd got %b exp 0", bus.par_odd); end
        n_chk++; if (bus.done_id !== 2'd0) begin n_fail++; $display("FAIL basic_done_id got %0d exp 0", bus.done_id); end
        n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_done got %b exp 1", bus.busy); end
        @(negedge clock);
        #1;
        n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b exp 0", bus.done); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_idle got %b exp 0", bus.busy); end
        n_chk++; if (bus.sum !== 8'h10) begin n_fail++; $display("FAIL basic_sum_hold got %h exp 10", bus.sum); end
    endtask

    task automatic test_overflow();
        int n;
        @(negedge clock);
        bus.req = 4'b0001;
        bus.op_a[7:0] = 8'hFF;
        bus.op_b[7:0] = 8'h01;
        #1;
        n_chk++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL ovf_gnt got %b exp 0001", bus.gnt); end
        @(posedge clock);
        #1 bus.req = '0;
        wait_done(n);
        n_chk++; if (n !== 9) begin n_fail++; $display("FAIL ovf_latency got %0d exp 9", n); end
        n_chk++; if (bus.sum !== 8'h00) begin n_fail++; $display("FAIL ovf_sum got %h exp 00", bus.sum); end
        n_chk++; if (bus.cout !== 1'b1) begin n_fail++; $display("FAIL ovf_cout got %b exp 1", bus.cout); end
        n_chk++; if (bus.par_even !== 1'b0) begin n_fail++; $display("FAIL ovf_par_even got %b exp 0", bus.par_even); end
        n_chk++; if (bus.par_odd !== 1'b1) begin n_fail++; $display("FAIL ovf_par_odd got %b exp 1", bus.par_odd); end
    endtask

    task automatic test_alternating();
        int n;
        @(negedge clock);
        bus.req = 4'b0001;
        bus.op_a[7:0] = 8'hAA;
        bus.op_b[7:0] = 8'h55;
        #1;
        @(posedge clock);
        #1 bus.req = '0;
        wait_done(n);
        n_chk++; if (n !== 9) begin n_fail++; $display("FAIL alt_latency got %0d exp 9", n); end
        n_chk++; if (bus.sum !== 8'hFF) begin n_fail++; $display("FAIL alt_sum got %h exp ff", bus.sum); end
        n_chk++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL alt_cout got %b exp 0", bus.cout); end
        n_chk++; if (bus.par_even !== 1'b0) begin n_fail++; $display("FAIL alt_par_even got %b exp 0", bus.par_even); end
    endtask

    task automatic test_rotation();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_s [4] = '{8'h12, 8'h12, 8'h00, 8'h04};
        logic exp_c [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic exp_p [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int ng = 0;
        int nd = 0;
        int last = 0;
        int n;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        bus.op_a = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.op_b = {8'hC0, 8'hCD, 8'hF0, 8'h01};
        bus.req = 4'b1111;
        #1;
        for (int cyc = 0; cyc < 60 && ng < 5; cyc++) begin
            if (bus.gnt !== 4'b0000) begin
                n_chk++; if (bus.gnt !== 4'b0001 << order[ng]) begin n_fail++; $display("FAIL rot_gnt%0d got %b exp idx %0d", ng, bus.gnt, order[ng]); end
                if (ng > 0) begin
                    n_chk++; if (cyc - last !== 10) begin n_fail++; $display("FAIL rot_spacing%0d got %0d exp 10", ng, cyc - last); end
                end
                last = cyc;
                ng++;
            end
            if (bus.done) begin
                n_chk++; if (bus.done_id !== 2'(order[nd])) begin n_fail++; $display("FAIL rot_done_id%0d got %0d exp %0d", nd, bus.done_id, order[nd]); end
                n_chk++; if ({bus.cout, bus.sum} !== {exp_c[order[nd]], exp_s[order[nd]]}) begin n_fail++; $display("FAIL rot_sum%0d got %h exp %h", nd, {bus.cout, bus.sum}, {exp_c[order[nd]], exp_s[order[nd]]}); end
                n_chk++; if (bus.par_even !== exp_p[order[nd]]) begin n_fail++; $display("FAIL rot_par%0d got %b exp %b", nd, bus.par_even, exp_p[order[nd]]); end
                nd++;
            end
            @(negedge clock);
            #1;
        end
        bus.req = '0;
        n_chk++; if (ng !== 5 || nd !== 4) begin n_fail++; $display("FAIL rot_counts got %0d/%0d exp 5/4", ng, nd); end
        wait_done(n);
        n_chk++; if (n !== 8) begin n_fail++; $display("FAIL rot_last_latency got %0d exp 8", n); end
        n_chk++; if (bus.done_id !== 2'd0 || bus.sum !== 8'h12) begin n_fail++; $display("FAIL rot_last got id %0d sum %h exp id 0 sum 12", bus.done_id, bus.sum); end
    endtask

    task automatic test_capture_wrap();
        int n;
        @(negedge clock);
        bus.op_a[23:16] = 8'h3C;
        bus.op_b[23:16] = 8'h0A;
        bus.req = 4'b0100;
        #1;
        n_chk++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL cap_gnt got %b exp 0100", bus.gnt); end
        @(posedge clock);
        #1;
        bus.req = '0;
        bus.op_a[23:16] = 8'hFF;
        bus.op_b[23:16] = 8'hFF;
        @(negedge clock);
        @(negedge clock);
        bus.req = 4'b0110;
        bus.op_a[15:8] = 8'h80;
        bus.op_b[15:8] = 8'h81;
        #1;
        n_chk++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL cap_no_gnt_in_add got %b exp 0000", bus.gnt); end
        wait_done(n);
        n_chk++; if (n !== 7) begin n_fail++; $display("FAIL cap_latency got %0d exp 7", n); end
        n_chk++; if ({bus.cout, bus.sum} !== 9'h046) begin n_fail++; $display("FAIL cap_sum got %h exp 046", {bus.cout, bus.sum}); end
        n_chk++; if (bus.par_even !== 1'b1 || bus.par_odd !== 1'b0) begin n_fail++; $display("FAIL cap_par got %b%b exp 10", bus.par_even, bus.par_odd); end
        n_chk++; if (bus.done_id !== 2'd2) begin n_fail++; $display("FAIL cap_done_id got %0d exp 2", bus.done_id); end
        n_chk++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL cap_no_gnt_in_done got %b exp 0000", bus.gnt); end
        @(negedge clock);
        #1;
        n_chk++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL wrap_gnt got %b exp 0010", bus.gnt); end
        @(posedge clock);
        #1 bus.req = '0;
        wait_done(n);
        n_chk++; if (n !== 9) begin n_fail++; $display("FAIL wrap_latency got %0d exp 9", n); end
        n_chk++; if ({bus.cout, bus.sum} !== 9'h101) begin n_fail++; $display("FAIL wrap_sum got %h exp 101", {bus.cout, bus.sum}); end
        n_chk++; if (bus.done_id !== 2'd1) begin n_fail++; $display("FAIL wrap_done_id got %0d exp 1", bus.done_id); end
    endtask

    task automatic test_reset_abort();
        int n;
        logic seen = 1'b0;
        @(negedge clock);
        bus.op_a[7:0] = 8'h01;
        bus.op_b[7:0] = 8'h02;
        bus.req = 4'b0001;
        #1;
        n_chk++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL abort_gnt got %b exp 0001", bus.gnt); end
        @(posedge clock);
        #1 bus.req = '0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_state got busy %b done %b exp 0 0", bus.busy, bus.done); end
        n_chk++; if (bus.sum !== 8'h00 || bus.cout !== 1'b0) begin n_fail++; $display("FAIL abort_sum got %h/%b exp 00/0", bus.sum, bus.cout); end
        n_chk++; if (bus.par_even !== 1'b0 || bus.par_odd !== 1'b1) begin n_fail++; $display("FAIL abort_par got %b%b exp 01", bus.par_even, bus.par_odd); end
        n_chk++; if (bus.done_id !== 2'd0) begin n_fail++; $display("FAIL abort_done_id got %0d exp 0", bus.done_id); end
        repeat (15) begin
            @(negedge clock);
            #1;
            if (bus.done) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %b exp 0", seen); end
        @(negedge clock);
        bus.req = 4'b1111;
        #1;
        n_chk++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL abort_ptr_gnt got %b exp 0001", bus.gnt); end
        @(posedge clock);
        #1 bus.req = '0;
        wait_done(n);
        n_chk++; if (n !== 9 || {bus.cout, bus.sum} !== 9'h003) begin n_fail++; $display("FAIL abort_rerun got lat %0d sum %h exp 9 003", n, {bus.cout, bus.sum}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_alternating();
        test_rotation();
        test_capture_wrap();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
